macguffin_sbox_seq: RTL and testbench

Time-multiplexed, programmable S-box layer for the MacGuffin F-function datapath. It takes one NBOX*IN_W-bit word, passes each IN_W-bit slice through its own writable lookup table, and returns the NBOX*OUT_W-bit result. LANES table lookups run per cycle, so area trades against latency. Valid/ready handshakes on input and output let it sit between the expansion stage and the XOR-into-block stage.

---
 rtl/macguffin_sbox_seq.sv | 136 +++++++++++++
 tb/tb_macguffin_sbox_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/macguffin_sbox_seq.sv
// MacGuffin S-box layer with writable per-box tables.
// LANES lookups run per cycle, so a word takes NBOX/LANES cycles and the result is fully registered.
module macguffin_sbox_seq #(
   parameter int NBOX  = 8,
   parameter int IN_W  = 6,
   parameter int OUT_W = 2,
   parameter int LANES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NBOX*IN_W-1:0]      in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NBOX*OUT_W-1:0]     out_data,
   input  logic                      cfg_we,
   input  logic [$clog2(NBOX)-1:0]   cfg_box,
   input  logic [IN_W-1:0]           cfg_addr,
   input  logic [OUT_W-1:0]          cfg_data,
   output logic                      busy
);

   localparam int G     = NBOX / LANES;
   localparam int CNT_W = (G > 1) ? $clog2(G) : 1;
   localparam int BOX_W = (NBOX > 1) ? $clog2(NBOX) : 1;
   localparam int DEPTH = 1 << IN_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NBOX*IN_W-1:0]     in_q, in_d;
   logic [NBOX*OUT_W-1:0]    out_q, out_d;
   logic [OUT_W-1:0]         tbl_q [NBOX][DEPTH];
   logic                     last_grp;
   logic                     cfg_ok;
   logic [BOX_W-1:0]         lane_box;
   logic [IN_W-1:0]          lane_addr;

   assign last_grp = (cnt_q == CNT_W'(G - 1));
   assign cfg_ok   = cfg_we && (state_q != S_RUN) && (32'(cfg_box) < NBOX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         in_q    <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         in_q    <= in_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      in_d    = in_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               in_d    = in_data;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last_grp) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  in_d    = in_data;
                  cnt_d   = '0;
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane j serves box cnt*LANES+j; slices outside the active group keep their old value.
   always_comb begin
      out_d     = out_q;
      lane_box  = '0;
      lane_addr = '0;
      if (state_q == S_RUN) begin
         for (int unsigned j = 0; j < LANES; j++) begin
            lane_box  = BOX_W'(32'(cnt_q) * LANES + j);
            lane_addr = in_q[lane_box*IN_W +: IN_W];
            out_d[lane_box*OUT_W +: OUT_W] = tbl_q[lane_box][lane_addr];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned b = 0; b < NBOX; b++) begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
               tbl_q[b][a] <= OUT_W'(a);
            end
         end
      end else if (cfg_ok) begin
         tbl_q[cfg_box][cfg_addr] <= cfg_data;
      end
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: in_ready = 1'b1;
         S_RUN:  busy = 1'b1;
         S_DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   assign out_data = out_q;

endmodule

// File: tb/tb_macguffin_sbox_seq.sv
// Scoreboard bench for macguffin_sbox_seq: stimulus pushes expected words, a monitor pops on each output transfer.
module tb_macguffin_sbox_seq;

   localparam int NBOX = 8;
   localparam int IN_W = 6;
   localparam int OUT_W = 2;
   localparam int LANES = 2;
   localparam int G = NBOX / LANES;
   localparam logic [47:0] W5 = 48'h145145145145;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [47:0] in_data;
   logic [15:0] out_data;
   logic        cfg_we;
   logic [2:0]  cfg_box;
   logic [5:0]  cfg_addr;
   logic [1:0]  cfg_data;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [47:0] in_data8;
   logic [15:0] out_data8;

   logic [1:0]  rdy_mode;
   logic        rnd_rdy;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_q[$];
   int          lat_q[$];
   logic        prev_ov = 1'b0;
   logic [1:0]  tbl_m [8][64];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign out_ready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];

   initial begin
      rnd_rdy = 1'b0;
      forever begin
         @(posedge clk);
         #1 rnd_rdy = 1'($urandom_range(0, 1));
      end
   end

   macguffin_sbox_seq #(.NBOX(NBOX), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .cfg_we(cfg_we), .cfg_box(cfg_box), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy)
   );

   macguffin_sbox_seq #(.NBOX(NBOX), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .cfg_we(1'b0), .cfg_box(3'd0), .cfg_addr(6'd0), .cfg_data(2'd0),
      .busy(busy8)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [47:0] w);
      logic [15:0] r;
      r = '0;
      for (int b = 0; b < 8; b++) r[b*2 +: 2] = tbl_m[b][w[b*6 +: 6]];
      return r;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 8; b++)
         for (int a = 0; a < 64; a++) tbl_m[b][a] = 2'(a);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [47:0] w, input logic [15:0] exp);
      int  n;
      bit  ok;
      n = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      while (n < 200 && !ok) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            exp_q.push_back(exp);
            lat_q.push_back(cyc);
         end
         n++;
      end
      if (!ok) chk("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic cfg_write(input int b, input int a, input logic [1:0] d, input bit upd);
      cfg_we   = 1'b1;
      cfg_box  = 3'(b);
      cfg_addr = 6'(a);
      cfg_data = d;
      @(posedge clk);
      #1 cfg_we = 1'b0;
      if (upd) tbl_m[b][a] = d;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (lat_q.size() == 0) chk("unexpected_valid", 64'(lat_q.size()), 64'd1);
            else chk("latency", 64'(cyc - lat_q.pop_front()), 64'(G + 1));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_output", 64'(exp_q.size()), 64'd1);
            else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
         end
         prev_ov = out_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;
      logic [47:0] w;
      int          n;
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0;
      cfg_we = 1'b0; cfg_box = '0; cfg_addr = '0; cfg_data = '0;
      in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
      rdy_mode = 2'd1;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // identity tables
      send(W5, 16'h5555);
      drain();

      // table writes while busy must be dropped
      send(W5, 16'h5555);
      chk("busy_in_run", 64'(busy), 64'd1);
      cfg_write(1, 5, 2'd0, 1'b0);
      drain();
      send(W5, 16'h5555);
      drain();

      cfg_write(0, 5, 2'd3, 1'b1);
      cfg_write(7, 5, 2'd0, 1'b1);
      send(W5, 16'h1557);
      drain();

      // stall in DONE, then release with a new word on the same cycle
      rdy_mode = 2'd0;
      send(48'hFFFF_FFFF_FFFF, 16'hFFFF);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reach_done", 64'(out_valid), 64'd1);
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_data", 64'(out_data), 64'(held));
      end
      @(posedge clk);
      #1 rdy_mode = 2'd1;
      send(W5, 16'h1557);
      drain();

      // full reprogramming, then random traffic
      for (int b = 0; b < 8; b++)
         for (int a = 0; a < 64; a++)
            cfg_write(b, a, 2'((a * 7 + b * 3 + (a >> 2)) & 3), 1'b1);
      rdy_mode = 2'd2;
      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         w = 48'({$urandom(), $urandom()});
         send(w, exp_word(w));
      end
      rdy_mode = 2'd1;
      drain();

      // reset in the middle of a word
      send(W5, exp_word(W5));
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      exp_q.delete();
      lat_q.delete();
      model_reset();
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_out_valid", 64'(out_valid), 64'd0);
      chk("postrst_busy", 64'(busy), 64'd0);
      chk("postrst_in_ready", 64'(in_ready), 64'd1);
      chk("postrst_out_data", 64'(out_data), 64'd0);
      @(posedge clk);
      #1;
      send(W5, 16'h5555);
      drain();

      // single-group variant
      in_valid8 = 1'b1;
      in_data8  = W5;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready8 && n < 20);
      chk("l8_accept", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(negedge clk);
      chk("l8_busy", 64'(busy8), 64'd1);
      chk("l8_not_yet_valid", 64'(out_valid8), 64'd0);
      @(negedge clk);
      chk("l8_valid", 64'(out_valid8), 64'd1);
      chk("l8_data", 64'(out_data8), 64'h5555);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
